// File: rtl/i2c_regfile.sv
// rtl/i2c_regfile.sv - pointer-addressed register bank fed by the i2c slave byte stream.
// Optional readback port pair enabled by I2C_REGFILE_READBACK_EN.
module i2c_regfile #(
    parameter int         NUM_REGS  = 8,
    parameter int         PTR_W     = 3,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            data,
    input  logic                  data_valid_i,
    input  logic                  start,
    input  logic                  stop,
`ifdef I2C_REGFILE_READBACK_EN
    input  logic                  rd_ack_i,
    output logic [7:0]            rd_data_o,
`endif
    output logic [NUM_REGS*8-1:0] regs_o,
    output logic [PTR_W-1:0]      ptr_o,
    output logic                  wr_strobe_o,
    output logic [PTR_W-1:0]      wr_addr_o,
    output logic [7:0]            wr_data_o,
    output logic                  err_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {IDLE, PTR, DATA, DROP} state_t;

    state_t     state, state_nxt;
    logic [7:0] regs [NUM_REGS];
    logic       in_range;
    logic       do_write, do_load, do_err, rd_step;

    assign in_range = ({24'd0, data} < NUM_REGS);

    always_comb begin
        do_write = 1'b0;
        do_load  = 1'b0;
        do_err   = 1'b0;
        rd_step  = 1'b0;
        // A START in the same cycle as a byte always discards the byte.
        if (!start) begin
            do_write = data_valid_i && (state == DATA);
            do_load  = data_valid_i && (state == PTR) && in_range;
            do_err   = data_valid_i && (state == PTR) && !in_range;
`ifdef I2C_REGFILE_READBACK_EN
            rd_step  = rd_ack_i && !data_valid_i && ((state == PTR) || (state == DATA));
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = PTR;
        end else begin
            case (state)
                PTR: begin
                    if (do_load || rd_step) state_nxt = DATA;
                    else if (do_err)        state_nxt = DROP;
                end
                default: state_nxt = state;
            endcase
            // The byte accompanying STOP is still processed above; only the state is overridden.
            if (stop && (state != IDLE)) state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr_o       <= '0;
            wr_strobe_o <= 1'b0;
            wr_addr_o   <= '0;
            wr_data_o   <= 8'h00;
            err_o       <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
        end else begin
            state       <= state_nxt;
            wr_strobe_o <= do_write;
            if (start)       err_o <= 1'b0;
            else if (do_err) err_o <= 1'b1;
            if (do_load) ptr_o <= data[PTR_W-1:0];
            if (do_write) begin
                regs[ptr_o] <= data;
                wr_addr_o   <= ptr_o;
                wr_data_o   <= data;
            end
            // Power-of-two bank: natural overflow of the pointer gives the wrap.
            if (do_write || rd_step) ptr_o <= ptr_o + PTR_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_o[8*g +: 8] = regs[g];
    end

    assign busy_o = (state != IDLE);

`ifdef I2C_REGFILE_READBACK_EN
    assign rd_data_o = regs[ptr_o];
`endif

endmodule

// File: doc/i2c_regfile.md
# i2c_regfile

Register bank directly downstream of the `i2c` slave receiver. It consumes the slave's byte stream and its start/stop pulses. The first byte of each write transaction sets a register pointer. Each following byte is written to the pointed register, and the pointer then auto-increments with wrap-around. Register contents are exported in parallel to the rest of the chip as configuration outputs.

## Interface
- `NUM_REGS`, 8: number of 8-bit registers; must be a power of two, range 2–128.
- `PTR_W`, 3: pointer width; must equal log2(`NUM_REGS`).
- `RESET_VAL`, 8'h00: reset value of every register.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `data`  in  8  byte from the `i2c` slave.
- `data_valid_i`  in  1  one-cycle pulse; `data` is valid.
- `start`  in  1  one-cycle pulse on START or repeated START.
- `stop`  in  1  one-cycle pulse on STOP.
- `regs_o`  out  `NUM_REGS`*8  flattened registers; reg n is at bits [8n+7:8n].
- `ptr_o`  out  `PTR_W`  current register pointer.
- `wr_strobe_o`  out  1  one-cycle pulse after each register write.
- `wr_addr_o`  out  `PTR_W`  index of the last write.
- `wr_data_o`  out  8  data of the last write.
- `err_o`  out  1  sticky out-of-range pointer flag.
- `busy_o`  out  1  high while the state is not IDLE.

## Operation
- Upstream contract:
  - `data_valid_i` pulses only for bytes following a matched address; the address byte itself is never presented.
  - All inputs are already synchronous to `clk` and last one cycle.
- State machine:
  - IDLE: `start` → PTR. `data_valid_i` and `stop` are ignored.
  - PTR:
    - If `data_valid_i` and `data` < `NUM_REGS`: load `ptr` = `data[PTR_W-1:0]` and go to DATA. No register write.
    - If `data_valid_i` and `data` ≥ `NUM_REGS`: set `err_o` and go to DROP.
  - DATA: on `data_valid_i`, write `regs[ptr]` = `data` and set `ptr` = (`ptr`+1) mod `NUM_REGS`.
  - DROP: all bytes are discarded.
  - From PTR, DATA or DROP: `stop` → IDLE; `start` → PTR.
- Priority and simultaneous events:
  - `start` and `data_valid_i` in the same cycle: `start` wins and the byte is discarded.
  - `stop` and `data_valid_i` in the same cycle: the byte is processed as in the current state, then the state becomes IDLE.
  - `start` and `stop` in the same cycle: treated as `start`.
- `err_o` is cleared by `reset` or by the next `start`.
- `ptr_o` holds its value across STOP, so a later transaction that sends no data keeps the pointer.
- Wrap: writing reg `NUM_REGS`-1 sets `ptr` to 0.
- `busy_o` = (state != IDLE).

## Timing
- Reset (async assert, sync release):
  - state IDLE, all regs = `RESET_VAL`, `ptr_o` = 0.
  - `wr_strobe_o`, `wr_addr_o`, `wr_data_o`, `err_o`, `busy_o` = 0.
- Byte sampled at edge N with `data_valid_i` in DATA:
  - `regs_o` and `ptr_o` are updated at edge N.
  - `wr_strobe_o` is high for exactly cycle N→N+1.
  - `wr_addr_o` and `wr_data_o` are updated at edge N and then hold.
- Latency: 1 clock from valid byte to visible register.
- Back-to-back `data_valid_i` on consecutive cycles is supported; each gives one write and one strobe.
- Asserting `reset` mid-transaction aborts it immediately; a strobe in flight is cancelled.

## Configuration
- `I2C_REGFILE_READBACK_EN`:
  - Defined:
    - Adds port `rd_data_o` (out, 8), combinational `regs[ptr]`.
    - Adds port `rd_ack_i` (in, 1); each `rd_ack_i` pulse in PTR or DATA increments `ptr` mod `NUM_REGS`.
    - A read pulse in PTR moves the state to DATA.
    - `rd_ack_i` in IDLE or DROP is ignored.
    - `rd_ack_i` coinciding with `data_valid_i`: the write takes precedence and the pointer increments once.
  - Undefined: neither port exists; the block is write-only.

## Test plan
- Reset: assert `reset` with registers holding data → all `regs_o` = 00, `ptr_o` = 0, `err_o` = 0, `busy_o` = 0, independent of clock.
- Write sequence `start`, 0x02, 0xA8, 0x55, `stop` → reg2 = A8, reg3 = 55, `ptr_o` = 4, exactly 2 `wr_strobe_o` pulses, `busy_o` falls after `stop`.
- Wrap: `start`, 0x07, 0x11, 0x22 → reg7 = 11, reg0 = 22, `ptr_o` = 1.
- Out-of-range pointer: `start`, 0x71, 0xA8, `stop` → `err_o` = 1, no strobe, regs unchanged; next `start` clears `err_o`.
- Repeated start mid-write:
  - Stimulus: `start`, 0x01, 0xAA, `start`, 0x05, 0xBB; also `start` coincident with a valid 0xCC.
  - Response: reg1 = AA, reg5 = BB, reg2 unchanged, 0xCC dropped.
- Readback (macro defined): after reg3 = 55 and reg4 = 66, `start`, 0x03, then two `rd_ack_i` pulses → `rd_data_o` reads 55, then 66, then `ptr_o` = 5.
